imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_enc_pkg.sv | 66 ++++++
 rtl/imm_rot_check.sv | 34 +++
 rtl/imm_encoder.sv | 144 ++++++++++++++
 tb/tb_imm_encoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_enc_pkg.sv
// rtl/imm_enc_pkg.sv - shared types, constants and direct-format encoder for imm_encoder
//
// Purpose: holds the immediate format selects, the encoder FSM state type,
//   the datapath widths and the combinational encoder for the formats that
//   need no search (imm8, imm12, branch offset).
// Ports: none (package).
// Configuration: IMM_ENC_ROT_EN is consumed by imm_encoder and imm_rot_check.

package imm_enc_pkg;

  localparam int VALUE_W = 32;  // width of the value to encode
  localparam int FIELD_W = 24;  // width of the encoded field
  localparam int ROT_W   = 4;   // rotation counter width
  localparam int IMM8_W  = 8;   // width of the rotated/plain byte immediate

  localparam logic [1:0] SEL_IMM8   = 2'd0;
  localparam logic [1:0] SEL_IMM12  = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;
  localparam logic [1:0] SEL_ROT    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic               ok;
    logic [FIELD_W-1:0] field;
  } enc_result_t;

  // Single-cycle encodings. The rotated format is handled by the search
  // path in the top, so it reports "not representable" here.
  function automatic enc_result_t encode_direct(input logic [VALUE_W-1:0] value,
                                                input logic [1:0]         sel);
    enc_result_t res;
    res.ok    = 1'b0;
    res.field = '0;
    case (sel)
      SEL_IMM8: begin
        if (value[VALUE_W-1:IMM8_W] == '0) begin
          res.ok    = 1'b1;
          res.field = {{(FIELD_W-IMM8_W){1'b0}}, value[IMM8_W-1:0]};
        end
      end
      SEL_IMM12: begin
        if (value[VALUE_W-1:12] == '0) begin
          res.ok    = 1'b1;
          res.field = {{(FIELD_W-12){1'b0}}, value[11:0]};
        end
      end
      SEL_BRANCH: begin
        // Word-aligned offset whose upper bits are a pure sign extension
        // of bit 25, so value[25:2] reproduces it exactly.
        if ((value[1:0] == 2'b00) && (value[VALUE_W-1:25] == {(VALUE_W-25){value[25]}})) begin
          res.ok    = 1'b1;
          res.field = value[25:2];
        end
      end
      SEL_ROT: ;
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_rot_check.sv
// rtl/imm_rot_check.sv - tests one rotate-left-by-2r candidate for an 8-bit fit
//
// Purpose: rotates value left by 2*r and reports whether the result fits in
//   the low byte.
// Ports:
//   value_i  in  32  value under test
//   r_i      in  4   rotation step (rotation amount is 2*r_i)
//   hit_o    out 1   rotated value has bits [31:8] all zero
//   imm8_o   out 8   low byte of the rotated value
// Configuration: only present when IMM_ENC_ROT_EN is defined.

`ifdef IMM_ENC_ROT_EN
module imm_rot_check
  import imm_enc_pkg::*;
(
  input  logic [VALUE_W-1:0] value_i,
  input  logic [ROT_W-1:0]   r_i,
  output logic               hit_o,
  output logic [IMM8_W-1:0]  imm8_o
);

  logic [5:0]         shamt;
  logic [VALUE_W-1:0] cand;

  always_comb begin
    shamt = {1'b0, r_i, 1'b0};
    // A right shift by the full width yields zero, which makes r=0 a no-op.
    cand   = (value_i << shamt) | (value_i >> (6'd32 - shamt));
    hit_o  = (cand[VALUE_W-1:IMM8_W] == '0);
    imm8_o = cand[IMM8_W-1:0];
  end

endmodule
`endif

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - encodes a 32-bit value into a 24-bit immediate field
//
// Purpose: accepts one request at a time, encodes it in the selected format
//   and holds the result until the consumer takes it.
// Ports:
//   clk        in  1   rising-edge clock
//   rst        in  1   asynchronous active-high reset
//   in_valid   in  1   request present
//   in_ready   out 1   encoder idle and able to accept
//   in_value   in  32  value to encode
//   in_sel     in  2   0=imm8, 1=imm12, 2=branch offset, 3=rotated imm8
//   out_valid  out 1   result present
//   out_ready  in  1   consumer accepts result
//   out_field  out 24  encoded field (0 when not representable)
//   out_ok     out 1   value representable in the selected format
// Configuration: IMM_ENC_ROT_EN enables the rotated-imm8 search; without it
//   sel 3 always reports not representable after one cycle.

module imm_encoder
  import imm_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  input  logic [1:0]         in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_field,
  output logic               out_ok
);

  state_e             state_q, state_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic               ok_q, ok_d;
  enc_result_t        direct;

  assign direct = encode_direct(in_value, in_sel);

`ifdef IMM_ENC_ROT_EN
  logic [VALUE_W-1:0] value_q, value_d;
  logic [ROT_W-1:0]   r_q, r_d;
  logic [VALUE_W-1:0] chk_value;
  logic [ROT_W-1:0]   chk_r;
  logic               chk_hit;
  logic [IMM8_W-1:0]  chk_imm8;

  // Rotation 0 is tested straight off the request in the accepting cycle,
  // so a hit at step r completes r+1 cycles after acceptance and the
  // SEARCH state walks steps 1..15 on the registered value.
  assign chk_value = (state_q == ST_SEARCH) ? value_q : in_value;
  assign chk_r     = (state_q == ST_SEARCH) ? r_q : '0;

  imm_rot_check u_rot_check (
    .value_i (chk_value),
    .r_i     (chk_r),
    .hit_o   (chk_hit),
    .imm8_o  (chk_imm8)
  );
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_field = field_q;
  assign out_ok    = ok_q;

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    ok_d    = ok_q;
`ifdef IMM_ENC_ROT_EN
    value_d = value_q;
    r_d     = r_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_DONE;
          ok_d    = direct.ok;
          field_d = direct.field;
`ifdef IMM_ENC_ROT_EN
          if (in_sel == SEL_ROT) begin
            value_d = in_value;
            if (chk_hit) begin
              ok_d    = 1'b1;
              field_d = {{(FIELD_W-ROT_W-IMM8_W){1'b0}}, chk_r, chk_imm8};
            end else begin
              state_d = ST_SEARCH;
              r_d     = ROT_W'(1);
            end
          end
`endif
        end
      end
`ifdef IMM_ENC_ROT_EN
      ST_SEARCH: begin
        if (chk_hit) begin
          state_d = ST_DONE;
          ok_d    = 1'b1;
          field_d = {{(FIELD_W-ROT_W-IMM8_W){1'b0}}, chk_r, chk_imm8};
        end else if (r_q == '1) begin
          state_d = ST_DONE;
          ok_d    = 1'b0;
          field_d = '0;
        end else begin
          r_d = r_q + ROT_W'(1);
        end
      end
`endif
      ST_DONE: begin
        // Return to IDLE only; a new request is taken no earlier than the
        // following edge.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      field_q <= '0;
      ok_q    <= 1'b0;
`ifdef IMM_ENC_ROT_EN
      value_q <= '0;
      r_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      ok_q    <= ok_d;
`ifdef IMM_ENC_ROT_EN
      value_q <= value_d;
      r_q     <= r_d;
`endif
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder with a behavioural model
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_field;
  logic        out_ok;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hold_req = 0;
  int last_seen = 0;

  typedef struct {
    logic [23:0] field;
    logic        ok;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_ok    (out_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: formats described arithmetically; latency counted in cycles
  // from the accepting cycle to the first cycle out_valid is seen.
  function automatic exp_t model(input logic [31:0] v, input logic [1:0] s);
    exp_t        e;
    longint      sv;
    logic [63:0] two;
    logic [31:0] cand;
    e.field = '0;
    e.ok    = 1'b0;
    e.lat   = 1;
    e.acc   = 0;
    case (s)
      2'd0: if (v < 32'd256) begin e.ok = 1'b1; e.field = v[23:0]; end
      2'd1: if (v < 32'd4096) begin e.ok = 1'b1; e.field = v[23:0]; end
      2'd2: begin
        sv = longint'($signed(v));
        if ((sv % 4 == 0) && (sv >= -(64'sd1 <<< 25)) && (sv < (64'sd1 <<< 25))) begin
          e.ok    = 1'b1;
          e.field = 24'(sv / 4);
        end
      end
      default: begin
`ifdef IMM_ENC_ROT_EN
        e.lat = 16;
        for (int r = 0; r < 16; r++) begin
          two  = {v, v};
          cand = 32'(two >> (32 - 2 * r));
          if (cand < 32'd256) begin
            e.ok    = 1'b1;
            e.field = 24'(r * 256 + int'(cand));
            e.lat   = r + 1;
            break;
          end
        end
`endif
      end
    endcase
    return e;
  endfunction

  task automatic send(input logic [31:0] v, input logic [1:0] s);
    int   w = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    in_sel   = s;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0, want 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    e     = model(v, s);
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = $urandom;
    in_sel   = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Consumer handshake driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_req > 0) begin
        out_ready = 1'b0;
        if (out_valid) hold_req--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial begin : monitor
    exp_t e;
    bit   first = 1'b1;
    int   seen = 0;
    bit   consumed = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        consumed = 1'b0;
        first    = 1'b1;
        seen     = 0;
        continue;
      end
      if (consumed) begin
        check("in_ready_after_consume", 32'(in_ready), 32'd1);
        check("out_valid_after_consume", 32'(out_valid), 32'd0);
        consumed = 1'b0;
      end
      if (out_valid) begin
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got field 0x%0h ok %0b, want no result", out_field, out_ok);
        end else begin
          e = exp_q[0];
          if (first) begin
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            first = 1'b0;
          end
          check("field", 32'(out_field), 32'(e.field));
          check("ok", 32'(out_ok), 32'(e.ok));
          seen++;
          if (out_ready) begin
            void'(exp_q.pop_front());
            first     = 1'b1;
            last_seen = seen;
            seen      = 0;
            consumed  = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] b;
    int          k;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    in_sel   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_field", 32'(out_field), 32'd0);
    check("rst_out_ok", 32'(out_ok), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases and format boundaries.
    send(32'h0000_00A5, 2'd0);
    send(32'hFFFF_FFF8, 2'd2);
    send(32'h0000_0006, 2'd2);
    send(32'hFF00_0000, 2'd3);
    send(32'h0000_0101, 2'd3);
    send(32'h0000_00FF, 2'd3);
    send(32'hC000_0003, 2'd3);
    send(32'h0000_00FF, 2'd0);
    send(32'h0000_0100, 2'd0);
    send(32'h0000_0FFF, 2'd1);
    send(32'h0000_1000, 2'd1);
    send(32'h01FF_FFFC, 2'd2);
    send(32'h0200_0000, 2'd2);
    send(32'hFE00_0000, 2'd2);
    send(32'hFDFF_FFFC, 2'd2);
    drain();

    // Consumer stalls three cycles with the result presented.
    hold_req = 3;
    send(32'h0000_0123, 2'd1);
    drain();
    check("hold_cycles_seen", 32'(last_seen >= 4), 32'd1);

    // Reset in the middle of an operation: no result may appear.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 32'h0000_0101;
    in_sel   = 2'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef IMM_ENC_ROT_EN
    repeat (3) @(posedge clk);
    #1;
`endif
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_ok", 32'(out_ok), 32'd0);
    check("abort_out_field", 32'(out_field), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release_in_ready", 32'(in_ready), 32'd1);
    check("abort_release_out_valid", 32'(out_valid), 32'd0);
    send(32'h0000_0FFF, 2'd1);
    drain();

    // Randomized traffic biased toward representable values.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: v = $urandom;
        1: v = $urandom_range(0, 300);
        2: v = $urandom_range(0, 5000);
        3: begin
          b = $urandom_range(0, 255);
          k = 2 * $urandom_range(0, 15);
          v = (b << k) | (b >> (32 - k));
          if ($urandom_range(0, 3) == 0) v = v ^ (32'd1 << $urandom_range(0, 31));
        end
        default: begin
          v = $urandom;
          v[31:25] = {7{v[25]}};
          if ($urandom_range(0, 1) == 1) v[1:0] = 2'b00;
        end
      endcase
      send(v, 2'($urandom_range(0, 3)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
